cacheline_arbiter: RTL

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/rv32i_types.sv | 20 ++
 rtl/cacheline_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cacheline arbiter: FSM state, grant encoding and
// the default address/line widths.
package rv32i_types;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter that multiplexes I-cache and D-cache line traffic onto a
// single physical memory port, one transaction at a time.
module cacheline_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,

  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic i_req, d_req, grant_i, grant_d;
  logic busy;

  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  // Under contention the side that did not win last time gets the port.
  assign grant_i = i_req & (~d_req | (last_grant_q == GRANT_D));
  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          addr_d       = icache_address;
          wr_d         = 1'b0;
          wdata_d      = '0;
        end else if (grant_d) begin
          // A simultaneous read+write is treated as a writeback.
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          addr_d       = dcache_address;
          wr_d         = dcache_write;
          wdata_d      = dcache_wdata;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == SERVE_I) || (state_q == SERVE_D);
    pmem_read    = busy & ~wr_q;
    pmem_write   = busy & wr_q;
    pmem_address = busy ? addr_q : '0;
    pmem_wdata   = busy ? wdata_q : '0;
    icache_resp  = (state_q == SERVE_I) & pmem_resp;
    dcache_resp  = (state_q == SERVE_D) & pmem_resp;
    icache_rdata = icache_resp ? pmem_rdata : '0;
    dcache_rdata = dcache_resp ? pmem_rdata : '0;
  end

  a_dcache_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(dcache_read && dcache_write))
    else $warning("dcache_read and dcache_write both high; write issued");

endmodule
